// File: rtl/frame_buffer_pacer.sv
// frame_buffer_pacer
// Collects IN_W-bit filtered samples in a circular buffer and emits them as
// OUT_W-bit slices (most significant slice first), one slice every PACE
// clk_out1 cycles. BURST mode fills the buffer to full and then drains it to
// empty. STREAM mode writes and drains at the same time. A write that cannot
// be stored is dropped and sets a sticky overflow flag.
//
// Ports
//   clk_out1     in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   din          in   IN_W-bit sample
//   din_valid    in   one-cycle write strobe
//   stream_mode  in   0 = BURST, 1 = STREAM
//   ovf_clr      in   clears the sticky overflow flag
//   dout         out  current output slice
//   dout_valid   out  one-cycle beat strobe for dout
//   full         out  level == DEPTH
//   empty        out  level == 0
//   level        out  words in the buffer (slice register not included)
//   overflow     out  sticky dropped-write flag
//   state        out  00 FILL, 01 DRAIN, 10 STREAM
module frame_buffer_pacer #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PACE  = 190
) (
    input  logic                     clk_out1,
    input  logic                     rst,
    input  logic [IN_W-1:0]          din,
    input  logic                     din_valid,
    input  logic                     stream_mode,
    input  logic                     ovf_clr,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [1:0]               state
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(PACE);
    localparam int unsigned REM_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {
        StFill   = 2'b00,
        StDrain  = 2'b01,
        StStream = 2'b10
    } state_e;

    state_e             st_q, st_d;
    logic [IN_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    sreg_q;   // remaining slices of the popped word, left-aligned
    logic [REM_W-1:0]   rem_q;    // slices still to emit from sreg_q
    logic [OUT_W-1:0]   dout_q;
    logic               dout_valid_q;
    logic               overflow_q;

    logic               tick, pending, beat, pop, wr_ok, is_full, is_empty;
    logic [IN_W-1:0]    rd_word;

    assign is_full  = (level_q == LVL_W'(DEPTH));
    assign is_empty = (level_q == '0);
    assign pending  = (rem_q != '0);
    assign tick     = (st_q != StFill) && (cnt_q == CNT_W'(PACE - 1));
    assign beat     = tick && (pending || !is_empty);
    // A fresh word is taken from the buffer only on the beat that emits its first slice.
    assign pop      = beat && !pending;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign wr_ok    = din_valid && (st_q != StDrain) && (!is_full || pop);
    assign rd_word  = mem[rd_ptr_q];

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StFill: begin
                if (stream_mode && is_empty) begin
                    st_d = StStream;
                end else if (is_full) begin
                    st_d = StDrain;
                end
            end
            StDrain: begin
                if (is_empty && !pending) begin
                    st_d = StFill;
                end
            end
            StStream: begin
                if (!stream_mode && is_empty && !pending) begin
                    st_d = StFill;
                end
            end
            default: st_d = StFill;
        endcase
    end

    // Buffer storage needs no reset; contents are don't-care until written.
    always_ff @(posedge clk_out1) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk_out1 or posedge rst) begin
        if (rst) begin
            st_q         <= StFill;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            sreg_q       <= '0;
            rem_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            st_q <= st_d;

            // Counter rests at 0 in FILL so the first beat lands PACE cycles after leaving it.
            if ((st_q == StFill) || (st_d == StFill) || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            dout_valid_q <= beat;
            if (beat) begin
                if (pending) begin
                    dout_q <= sreg_q[IN_W-1 -: OUT_W];
                    sreg_q <= sreg_q << OUT_W;
                    rem_q  <= rem_q - REM_W'(1);
                end else begin
                    dout_q   <= rd_word[IN_W-1 -: OUT_W];
                    sreg_q   <= rd_word << OUT_W;
                    rem_q    <= REM_W'(RATIO - 1);
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end

            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end

            if (wr_ok && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!wr_ok && pop) begin
                level_q <= level_q - LVL_W'(1);
            end

            // A refused write beats a simultaneous clear.
            if (din_valid && !wr_ok) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign state      = st_q;

endmodule

// File: tb/tb_frame_buffer_pacer.sv
module tb_frame_buffer_pacer;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int DEPTH = 64;
    localparam int PACE  = 4;
    localparam int RATIO = IN_W / OUT_W;

    logic              clk_out1 = 1'b0;
    logic              rst;
    logic [IN_W-1:0]   din;
    logic              din_valid;
    logic              stream_mode;
    logic              ovf_clr;
    logic [OUT_W-1:0]  dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic [6:0]        level;
    logic              overflow;
    logic [1:0]        state;

    always #5 clk_out1 = ~clk_out1;

    frame_buffer_pacer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .PACE  (PACE)
    ) dut (
        .clk_out1    (clk_out1),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .stream_mode (stream_mode),
        .ovf_clr     (ovf_clr),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .state       (state)
    );

    // Reference model: words waiting in a queue, slices of the current word in another.
    int               m_state;  // 0 FILL, 1 DRAIN, 2 STREAM
    int               m_cnt;
    logic [IN_W-1:0]  m_q[$];
    logic [OUT_W-1:0] m_sl[$];
    logic [OUT_W-1:0] m_dout;
    logic             m_dv;
    logic             m_ovf;

    int               n_vec;
    int               n_err;
    logic [OUT_W-1:0] got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_q.delete();
        m_sl.delete();
        m_dout  = '0;
        m_dv    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        int              lvl;
        int              nxt;
        bit              pend, tick, beat, pop, acc;
        logic [IN_W-1:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        lvl  = m_q.size();
        pend = (m_sl.size() > 0);
        tick = (m_state != 0) && (m_cnt == PACE - 1);
        beat = tick && (pend || lvl > 0);
        pop  = beat && !pend;
        acc  = din_valid && (m_state != 1) && (lvl < DEPTH || pop);
        nxt  = m_state;
        case (m_state)
            0: if (stream_mode && lvl == 0) nxt = 2; else if (lvl == DEPTH) nxt = 1;
            1: if (lvl == 0 && !pend) nxt = 0;
            2: if (!stream_mode && lvl == 0 && !pend) nxt = 0;
            default: nxt = 0;
        endcase
        m_dv = beat;
        if (beat) begin
            if (!pend) begin
                w = m_q.pop_front();
                for (int k = RATIO - 1; k >= 0; k--) m_sl.push_back(w[k*OUT_W +: OUT_W]);
            end
            m_dout = m_sl.pop_front();
        end
        if (din_valid) begin
            if (acc) m_q.push_back(din);
            else m_ovf = 1'b1;
        end else if (ovf_clr) begin
            m_ovf = 1'b0;
        end
        if (din_valid && acc && ovf_clr) m_ovf = 1'b0;
        m_cnt   = (m_state == 0 || nxt == 0) ? 0 : (m_cnt + 1) % PACE;
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("dout", dout, m_dout);
        chk("dout_valid", dout_valid, m_dv);
        chk("level", level, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("state", state, m_state);
    endtask

    task automatic cyc();
        @(posedge clk_out1);
        model_step();
        #1;
        check_all();
        if (dout_valid) got.push_back(dout);
    endtask

    task automatic run_until_fill(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (m_state == 0) break;
        end
        chk("back_to_fill", state, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [IN_W-1:0] ew[$];
        logic [IN_W-1:0] w;
        bit              saw_full;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; din = '0; din_valid = 1'b0; stream_mode = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // Burst: 64 sequential words, drain with a dropped write in the middle.
        got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            din = IN_W'(i); din_valid = 1'b1;
            cyc();
        end
        din_valid = 1'b0;
        chk("t1_full", full, 1);
        cyc();
        chk("t1_drain", state, 1);
        repeat (20) cyc();
        din = 16'hBEEF; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        chk("t2_ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("t2_ovf_clr", overflow, 0);
        run_until_fill(700);
        chk("t1_nbeats", got.size(), 2 * DEPTH);
        for (int i = 0; i < got.size() && i < 2 * DEPTH; i++) begin
            w = IN_W'(i / 2);
            chk("t1_beat", got[i], (i % 2 == 0) ? w[15:8] : w[7:0]);
        end

        // Stream: sparse writes, level never exceeds one.
        got.delete();
        stream_mode = 1'b1;
        cyc();
        chk("t3_stream", state, 2);
        for (int n = 0; n < 8; n++) begin
            din = 16'hA55A; din_valid = 1'b1;
            cyc();
            din_valid = 1'b0;
            for (int j = 0; j < 9; j++) begin
                cyc();
                chk("t3_level_le1", level <= 1, 1);
                chk("t3_not_full", full, 0);
            end
        end
        stream_mode = 1'b0;
        run_until_fill(100);
        chk("t3_nbeats", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++) begin
            chk("t3_beat", got[i], (i % 2 == 0) ? 8'hA5 : 8'h5A);
        end

        // Second burst with random data; pointers are offset so the buffer wraps.
        got.delete();
        ew.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w = IN_W'($urandom);
            ew.push_back(w);
            din = w; din_valid = 1'b1;
            cyc();
        end
        din_valid = 1'b0;
        run_until_fill(700);
        chk("t6_nbeats", got.size(), 2 * DEPTH);
        for (int i = 0; i < got.size() && i < 2 * DEPTH; i++) begin
            w = ew[i / 2];
            chk("t6_beat", got[i], (i % 2 == 0) ? w[15:8] : w[7:0]);
        end
        got.delete();
        repeat (10) cyc();
        chk("t6_no_fill_beats", got.size(), 0);

        // Stream saturated: writes every cycle, random clears.
        saw_full = 1'b0;
        stream_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            din = IN_W'($urandom); din_valid = 1'b1;
            ovf_clr = ($urandom_range(0, 15) == 0);
            cyc();
            if (full) saw_full = 1'b1;
        end
        din_valid = 1'b0; ovf_clr = 1'b0; stream_mode = 1'b0;
        chk("t4_reached_full", saw_full, 1);
        run_until_fill(700);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < DEPTH; i++) begin
            din = IN_W'($urandom); din_valid = 1'b1;
            cyc();
        end
        din_valid = 1'b0;
        got.delete();
        for (int i = 0; i < 200 && got.size() < 10; i++) cyc();
        chk("t5_ten_beats", got.size(), 10);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_dout", dout, 0);
        chk("t5_dv", dout_valid, 0);
        chk("t5_level", level, 0);
        chk("t5_empty", empty, 1);
        chk("t5_full", full, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_state", state, 0);
        model_reset();
        cyc();
        rst = 1'b0;
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
